// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared state encoding and word-size helpers for the RAM responder
package ram_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  function automatic int bytes_of(input int word_size);
    return word_size / 8;
  endfunction
endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: DEPTH x 8 synchronous single-port RAM, read-before-write, no reset
module ram_byte_array #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);
  logic [7:0] mem [DEPTH];
  // one-cycle registered read; write when enabled
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: word-wide CPU data-bus responder moving little-endian bytes to a byte RAM
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 write_en,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ready
);
  localparam int BYTES = bytes_of(WORD_SIZE);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam int WW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  localparam int PW = WORD_SIZE + 1;
  state_t state, state_n;
  logic [WORD_SIZE-1:0] a_r, d_r;
  logic we_r;
  logic [IW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic last, in_range, ram_we;
  logic [PW-1:0] cur;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  assign last = idx == IW'(BYTES - 1);
  assign cur = {1'b0, a_r} + PW'(idx);
  assign in_range = cur < PW'(DEPTH);
  assign ram_we = state == XFER && we_r && in_range;
  assign ram_din = d_r[8*idx +: 8];
  // loads prefetch the next byte one cycle ahead so each XFER cycle captures its byte
  assign ram_addr = state == IDLE ? AW'(addr) : AW'(cur + PW'(state == XFER && !we_r));
  ram_byte_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );
  // next-state logic
  always_comb begin
    state_n = state == IDLE ? (enable ? (WAIT_STATES == 0 ? XFER : WAIT) : IDLE) :
              state == WAIT ? (wcnt == WW'(WAIT_STATES - 1) ? XFER : WAIT) :
              state == XFER ? (last ? DONE : XFER) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // request latch, counters, load data assembly and registered ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= '0;
      d_r <= '0;
      we_r <= 1'b0;
      idx <= '0;
      wcnt <= '0;
      data_out <= '0;
      ready <= 1'b0;
    end else begin
      ready <= state_n == DONE;
      if (state == IDLE && enable) begin
        a_r <= addr;
        d_r <= data_in;
        we_r <= write_en;
        idx <= '0;
        wcnt <= '0;
        if (!write_en) data_out <= '0;
      end
      if (state == WAIT) wcnt <= wcnt + WW'(1);
      if (state == XFER) begin
        idx <= idx + IW'(1);
        if (!we_r) data_out[8*idx +: 8] <= in_range ? ram_dout : 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed self-checking bench for ram_responder
module tb_ram_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, write_en = 1'b0;
  logic [15:0] addr = '0, data_in = '0, data_out;
  logic ready;
  logic enable2 = 1'b0, write_en2 = 1'b0;
  logic [31:0] addr2 = '0, data_in2 = '0, data_out2;
  logic ready2;
  int checks = 0, errors = 0;
  int lat;
  always #5 clk = ~clk;
  ram_responder #(.WORD_SIZE(16), .DEPTH(256), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .write_en(write_en),
    .addr(addr), .data_in(data_in), .data_out(data_out), .ready(ready)
  );
  ram_responder #(.WORD_SIZE(32), .DEPTH(256), .WAIT_STATES(0)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .write_en(write_en2),
    .addr(addr2), .data_in(data_in2), .data_out(data_out2), .ready(ready2)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic we, input logic [15:0] a, input logic [15:0] d, output int l);
    @(posedge clk); #1;
    enable = 1'b1; write_en = we; addr = a; data_in = d;
    @(posedge clk); #1;
    enable = 1'b0;
    l = 0;
    while (!ready && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask
  task automatic acc2(input logic we, input logic [31:0] a, input logic [31:0] d, output int l);
    @(posedge clk); #1;
    enable2 = 1'b1; write_en2 = we; addr2 = a; data_in2 = d;
    @(posedge clk); #1;
    enable2 = 1'b0;
    l = 0;
    while (!ready2 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_dout", 64'(data_out), 64'd0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst_ready2", 64'(ready2), 64'd0);
    chk("rst_dout2", 64'(data_out2), 64'd0);
    acc(1'b1, 16'h0020, 16'hBEEF, lat);
    chk("st_lat", 64'(lat), 64'd3);
    acc(1'b0, 16'h0020, 16'h0000, lat);
    chk("ld_lat", 64'(lat), 64'd3);
    chk("ld_beef", 64'(data_out), 64'hBEEF);
    acc(1'b0, 16'h001F, 16'h0000, lat);
    chk("ld_order", 64'(data_out[15:8]), 64'hEF);
    acc(1'b0, 16'h0020, 16'h0000, lat);
    acc(1'b1, 16'h00FE, 16'h7700, lat);
    acc(1'b1, 16'h0100, 16'h0005, lat);
    chk("oor_st_lat", 64'(lat), 64'd3);
    chk("st_keeps_dout", 64'(data_out), 64'hBEEF);
    acc(1'b0, 16'h00FE, 16'h0000, lat);
    chk("ld_fe", 64'(data_out), 64'h7700);
    acc(1'b0, 16'h0100, 16'h0000, lat);
    chk("ld_100", 64'(data_out), 64'h0000);
    chk("ld_100_lat", 64'(lat), 64'd3);
    acc(1'b1, 16'h0000, 16'h9988, lat);
    acc(1'b1, 16'h00FF, 16'h1234, lat);
    acc(1'b0, 16'h00FF, 16'h0000, lat);
    chk("straddle_ld", 64'(data_out), 64'h0034);
    acc(1'b0, 16'h0000, 16'h0000, lat);
    chk("no_wrap", 64'(data_out), 64'h9988);
    acc(1'b1, 16'h0010, 16'h1111, lat);
    acc(1'b1, 16'h0012, 16'h2222, lat);
    @(posedge clk); #1;
    enable = 1'b1; write_en = 1'b0; addr = 16'h0010;
    @(posedge clk); #1;
    addr = 16'h0012;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat1", 64'(lat), 64'd3);
    chk("b2b_data1", 64'(data_out), 64'h1111);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("b2b_ready_drop", 64'(ready), 64'd0);
      if (lat == 2) enable = 1'b0;
    end while (!ready && lat < 20);
    chk("b2b_gap", 64'(lat), 64'd5);
    chk("b2b_data2", 64'(data_out), 64'h2222);
    acc(1'b1, 16'h0040, 16'h5555, lat);
    @(posedge clk); #1;
    enable = 1'b1; write_en = 1'b1; addr = 16'h0040; data_in = 16'hAAAA;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'd0);
    chk("mid_rst_dout", 64'(data_out), 64'd0);
    @(negedge clk) reset = 1'b0;
    acc(1'b0, 16'h0040, 16'h0000, lat);
    chk("mid_rst_bytes", 64'(data_out), 64'h55AA);
    acc2(1'b1, 32'h0000_0084, 32'h0000_0000, lat);
    acc2(1'b1, 32'h0000_0080, 32'h1122_3344, lat);
    chk("w32_st_lat", 64'(lat), 64'd4);
    acc2(1'b0, 32'h0000_0080, 32'h0000_0000, lat);
    chk("w32_ld_lat", 64'(lat), 64'd4);
    chk("w32_ld", 64'(data_out2), 64'h1122_3344);
    acc2(1'b0, 32'h0000_0081, 32'h0000_0000, lat);
    chk("w32_order", 64'(data_out2), 64'h0011_2233);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
